zeroriscy_rf_wb_arbiter: RTL and testbench

//  Writer-side front end of the flip-flop register file's single write port.

---
 rtl/zeroriscy_rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_zeroriscy_rf_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_rf_wb_arbiter.sv
// rtl/zeroriscy_rf_wb_arbiter.sv - register file write-port arbiter for core and PPU writebacks
// Also keeps the pending-destination scoreboard that flags RAW hazards for the decoder.
module zeroriscy_rf_wb_arbiter #(
    parameter int RV32E      = 0,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_we_i,
    input  logic [4:0]            core_waddr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    input  logic                  ppu_valid_i,
    output logic                  ppu_ready_o,
    input  logic [4:0]            ppu_waddr_i,
    input  logic [DATA_WIDTH-1:0] ppu_wdata_i,
    input  logic                  issue_i,
    input  logic [4:0]            issue_addr_i,
    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    input  logic [4:0]            raddr_c_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o,
    output logic                  core_stall_o,
    output logic                  err_o,
    output logic [4:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o
);
    localparam int AW   = (RV32E != 0) ? 4 : 5;
    localparam int NREG = 1 << AW;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    logic [AW-1:0]         fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [NREG-1:0]       pending, pending_next;
    logic                  err_q;

    logic [AW-1:0] core_idx, ppu_idx, issue_idx, head_idx;
    logic          core_wr, fifo_empty, fifo_full, push, pop, violation;

    assign core_idx  = core_waddr_i[AW-1:0];
    assign ppu_idx   = ppu_waddr_i[AW-1:0];
    assign issue_idx = issue_addr_i[AW-1:0];
    assign head_idx  = fifo_addr[rd_ptr];

    assign core_wr    = core_we_i && (core_idx != '0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pop        = !core_wr && !fifo_empty;
    assign push       = ppu_valid_i && !fifo_full;

    assign ppu_ready_o  = !fifo_full;
    assign core_stall_o = fifo_full;
    assign err_o        = err_q;

    assign hazard_a_o = pending[raddr_a_i[AW-1:0]];
    assign hazard_b_o = pending[raddr_b_i[AW-1:0]];
    assign hazard_c_o = pending[raddr_c_i[AW-1:0]];

    always_comb begin
        we_a_o    = 1'b0;
        waddr_a_o = '0;
        wdata_a_o = '0;
        if (core_wr) begin
            we_a_o    = 1'b1;
            waddr_a_o = 5'(core_idx);
            wdata_a_o = core_wdata_i;
        end else if (pop) begin
            we_a_o    = 1'b1;
            waddr_a_o = 5'(head_idx);
            wdata_a_o = fifo_data[rd_ptr];
        end
    end

    // Re-issuing a register whose result retires on this same edge is legal.
    always_comb begin
        violation = 1'b0;
        if (issue_i && issue_idx != '0 && pending[issue_idx] && !(pop && head_idx == issue_idx))
            violation = 1'b1;
        if (core_wr && pending[core_idx])
            violation = 1'b1;
        if (push && !pending[ppu_idx])
            violation = 1'b1;
    end

    always_comb begin
        pending_next = pending;
        if (pop)
            pending_next[head_idx] = 1'b0;
        if (issue_i)
            pending_next[issue_idx] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            err_q   <= 1'b0;
        end else begin
            pending <= pending_next;
            err_q   <= violation;
            if (push)
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ppu_idx;
            fifo_data[wr_ptr] <= ppu_wdata_i;
        end
    end
endmodule

// File: tb/tb_zeroriscy_rf_wb_arbiter.sv
// tb/tb_zeroriscy_rf_wb_arbiter.sv - self-checking bench for zeroriscy_rf_wb_arbiter
module tb_zeroriscy_rf_wb_arbiter;
    logic        clk = 0;
    logic        rst_n, core_we, ppu_valid, issue;
    logic [4:0]  core_waddr, ppu_waddr, issue_addr, raddr_a, raddr_b, raddr_c;
    logic [31:0] core_wdata, ppu_wdata;
    logic        ppu_ready, hz_a, hz_b, hz_c, stall, err, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        e_ready, e_hz_a, e_hz_b, e_hz_c, e_stall, e_err, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    int tests = 0, fails = 0;
    bit started = 0;

    always #5 clk = ~clk;

    zeroriscy_rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .core_we_i(core_we), .core_waddr_i(core_waddr),
        .core_wdata_i(core_wdata), .ppu_valid_i(ppu_valid), .ppu_ready_o(ppu_ready),
        .ppu_waddr_i(ppu_waddr), .ppu_wdata_i(ppu_wdata), .issue_i(issue),
        .issue_addr_i(issue_addr), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
        .raddr_c_i(raddr_c), .hazard_a_o(hz_a), .hazard_b_o(hz_b), .hazard_c_o(hz_c),
        .core_stall_o(stall), .err_o(err), .waddr_a_o(waddr), .wdata_a_o(wdata),
        .we_a_o(we));

    zeroriscy_rf_wb_arbiter #(.RV32E(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .core_we_i(core_we), .core_waddr_i(core_waddr),
        .core_wdata_i(core_wdata), .ppu_valid_i(ppu_valid), .ppu_ready_o(e_ready),
        .ppu_waddr_i(ppu_waddr), .ppu_wdata_i(ppu_wdata), .issue_i(issue),
        .issue_addr_i(issue_addr), .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
        .raddr_c_i(raddr_c), .hazard_a_o(e_hz_a), .hazard_b_o(e_hz_b), .hazard_c_o(e_hz_c),
        .core_stall_o(e_stall), .err_o(e_err), .waddr_a_o(e_waddr), .wdata_a_o(e_wdata),
        .we_a_o(e_we));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending set plus an ordered queue of buffered PPU results.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [31:0] pend;
    logic        m_err;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            pend  = 0;
            m_err = 0;
        end else begin
            bit   cw, pp, ps, v;
            ent_t h;
            cw = core_we && core_waddr != 0;
            pp = !cw && q.size() > 0;
            ps = ppu_valid && q.size() < 2;
            if (pp) h = q[0];
            v = 0;
            if (issue && issue_addr != 0 && pend[issue_addr] && !(pp && h.a == issue_addr)) v = 1;
            if (cw && pend[core_waddr]) v = 1;
            if (ps && !pend[ppu_waddr]) v = 1;
            if (pp) begin
                pend[h.a] = 0;
                void'(q.pop_front());
            end
            if (ps) q.push_back('{ppu_waddr, ppu_wdata});
            if (issue && issue_addr != 0) pend[issue_addr] = 1;
            m_err = v;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic        ewe;
            logic [4:0]  ea;
            logic [31:0] ed;
            ewe = 0; ea = 0; ed = 0;
            if (core_we && core_waddr != 0) begin
                ewe = 1; ea = core_waddr; ed = core_wdata;
            end else if (q.size() > 0) begin
                ewe = 1; ea = q[0].a; ed = q[0].d;
            end
            chk("we", 32'(we), 32'(ewe));
            chk("waddr", 32'(waddr), 32'(ea));
            chk("wdata", wdata, ed);
            chk("ready", 32'(ppu_ready), 32'(q.size() < 2));
            chk("stall", 32'(stall), 32'(q.size() == 2));
            chk("err", 32'(err), 32'(m_err));
            chk("hz_a", 32'(hz_a), 32'(raddr_a != 0 && pend[raddr_a]));
            chk("hz_b", 32'(hz_b), 32'(raddr_b != 0 && pend[raddr_b]));
            chk("hz_c", 32'(hz_c), 32'(raddr_c != 0 && pend[raddr_c]));
        end
    end

    task automatic pc;
        @(posedge clk);
        #1;
    endtask

    task automatic nc;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; core_we = 0; ppu_valid = 0; issue = 0;
        core_waddr = 0; ppu_waddr = 0; issue_addr = 0;
        raddr_a = 0; raddr_b = 0; raddr_c = 0; core_wdata = 0; ppu_wdata = 0;
        @(posedge clk);
        started = 1;
        pc;
        nc;
        chk("rst_ready", 32'(ppu_ready), 1);
        chk("rst_we", 32'(we), 0);
        chk("rst_err", 32'(err), 0);
        pc;
        rst_n = 1;

        // 1: single PPU result, port free
        raddr_a = 5; issue = 1; issue_addr = 5;
        nc; chk("t1_hz_pre", 32'(hz_a), 0); pc;
        issue = 0; ppu_valid = 1; ppu_waddr = 5; ppu_wdata = 32'hDEAD;
        nc; chk("t1_ready", 32'(ppu_ready), 1); chk("t1_hz_acc", 32'(hz_a), 1); chk("t1_we0", 32'(we), 0); pc;
        ppu_valid = 0;
        nc; chk("t1_we", 32'(we), 1); chk("t1_waddr", 32'(waddr), 5); chk("t1_wdata", wdata, 32'hDEAD);
        chk("t1_hz_wr", 32'(hz_a), 1); pc;
        nc; chk("t1_we_after", 32'(we), 0); chk("t1_hz_drop", 32'(hz_a), 0); pc;

        // 2: core busy every cycle fills the FIFO
        issue = 1; issue_addr = 7; pc;
        issue_addr = 8; pc;
        issue = 0; core_we = 1; core_waddr = 3; core_wdata = 32'h33;
        ppu_valid = 1; ppu_waddr = 7; ppu_wdata = 32'h77;
        nc; chk("t2_stall0", 32'(stall), 0); pc;
        ppu_waddr = 8; ppu_wdata = 32'h88;
        nc; chk("t2_core_wr", 32'(waddr), 3); pc;
        ppu_valid = 0;
        nc; chk("t2_stall", 32'(stall), 1); chk("t2_ready0", 32'(ppu_ready), 0); pc;
        core_we = 0;
        nc; chk("t2_x7", 32'(waddr), 7); chk("t2_x7d", wdata, 32'h77); pc;
        nc; chk("t2_x8", 32'(waddr), 8); chk("t2_x8d", wdata, 32'h88); chk("t2_ready1", 32'(ppu_ready), 1); pc;
        nc; chk("t2_idle", 32'(we), 0); pc;

        // 3: pop and re-issue of the same register on one edge
        raddr_b = 9; issue = 1; issue_addr = 9; pc;
        issue = 0; ppu_valid = 1; ppu_waddr = 9; ppu_wdata = 32'h99; pc;
        ppu_valid = 0; issue = 1; issue_addr = 9;
        nc; chk("t3_pop", 32'(waddr), 9); pc;
        issue = 0;
        nc; chk("t3_pend", 32'(hz_b), 1); chk("t3_err", 32'(err), 0); pc;
        ppu_valid = 1; ppu_wdata = 32'h9A; pc;
        ppu_valid = 0; pc;
        nc; chk("t3_clear", 32'(hz_b), 0); pc;

        // 4: protocol violations
        issue = 1; issue_addr = 4; pc;
        pc;
        issue = 0;
        nc; chk("t4_err_issue", 32'(err), 1); pc;
        core_we = 1; core_waddr = 4; core_wdata = 32'h44;
        nc; chk("t4_err_gap", 32'(err), 0); chk("t4_waw_wr", 32'(waddr), 4); pc;
        core_we = 0;
        nc; chk("t4_err_waw", 32'(err), 1); pc;
        ppu_valid = 1; ppu_waddr = 6; ppu_wdata = 32'h66;
        nc; chk("t4_err_gap2", 32'(err), 0); pc;
        ppu_valid = 0;
        nc; chk("t4_err_push", 32'(err), 1); chk("t4_push_wr", 32'(waddr), 6); pc;
        nc; chk("t4_err_end", 32'(err), 0); pc;

        // 5: core write to x0 leaves the port to the FIFO
        issue = 1; issue_addr = 2; pc;
        issue = 0; ppu_valid = 1; ppu_waddr = 2; ppu_wdata = 32'h22; pc;
        ppu_valid = 0; core_we = 1; core_waddr = 0; core_wdata = 32'hFFFF; raddr_c = 0;
        nc; chk("t5_we", 32'(we), 1); chk("t5_waddr", 32'(waddr), 2); chk("t5_wdata", wdata, 32'h22);
        chk("t5_hz0", 32'(hz_c), 0); pc;
        core_we = 0; pc;

        // 6: reset with buffered results and pending registers
        issue = 1; issue_addr = 10; pc;
        issue_addr = 11; pc;
        issue_addr = 12; pc;
        issue = 0; core_we = 1; core_waddr = 1; core_wdata = 32'h1;
        ppu_valid = 1; ppu_waddr = 10; ppu_wdata = 32'hA; pc;
        ppu_waddr = 11; ppu_wdata = 32'hB; pc;
        ppu_valid = 0; core_we = 0;
        nc; chk("t6_full", 32'(stall), 1); pc;
        rst_n = 0; pc;
        rst_n = 1; raddr_a = 10; raddr_b = 11; raddr_c = 12;
        nc; chk("t6_we", 32'(we), 0); chk("t6_hz", {hz_a, hz_b, hz_c}, 0); chk("t6_ready", 32'(ppu_ready), 1);
        chk("t6e_ready", 32'(e_ready), 1); pc;
        issue = 1; issue_addr = 5'h13; pc;
        issue = 0; raddr_a = 3; raddr_b = 5'h13;
        nc; chk("t6e_alias_a", 32'(e_hz_a), 1); chk("t6e_alias_b", 32'(e_hz_b), 1); chk("t6_noalias", 32'(hz_a), 0); pc;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
